sap3_ext_mem: RTL and testbench

- Off-chip-side memory stage directly downstream of the SAP-3 chip wrapper.
- Consumes the chip's 16-bit bus, mem_mar_we and mem_ram_we strobes; returns read data on mem_out, which feeds the chip's ui_in.
- Holds the memory address register (MAR) and a byte RAM.
- Includes a sequential program loader (valid/ready byte stream) that fills RAM from address 0 before the CPU runs.
- Serves as the FPGA/bench companion to the ASIC and as the golden memory model in system simulation.

---
 rtl/sap3_ext_mem_if.sv | 27 ++
 rtl/sap3_ext_mem.sv | 148 ++++++++++++++
 tb/tb_sap3_ext_mem.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sap3_ext_mem_if.sv
// CPU-side bus/strobe signals and the program-loader byte stream of the SAP-3 external memory.
// The slave modport belongs to the memory; the master modport belongs to the chip/bench.
interface sap3_ext_mem_if #(
    parameter int ADDR_W = 8
) ();
    logic [15:0]     bus;
    logic            mem_mar_we;
    logic            mem_ram_we;
    logic [7:0]      mem_out;
    logic            ld_start;
    logic [ADDR_W:0] ld_len;
    logic            ld_valid;
    logic [7:0]      ld_data;
    logic            ld_ready;
    logic            ld_busy;
    logic            ld_done;

    modport slave (
        input  bus, mem_mar_we, mem_ram_we, ld_start, ld_len, ld_valid, ld_data,
        output mem_out, ld_ready, ld_busy, ld_done
    );

    modport master (
        output bus, mem_mar_we, mem_ram_we, ld_start, ld_len, ld_valid, ld_data,
        input  mem_out, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/sap3_ext_mem.sv
// MAR + byte RAM with write-first registered read (mem_out one edge after MAR/RAM update).
// Loader accepts a byte whenever ld_ready (LOAD state); CPU strobes are dropped while busy.
module sap3_ext_mem #(
    parameter int ADDR_W    = 8,
    parameter bit INIT_ZERO = 1'b0
) (
    input  logic          CLK,
    input  logic          rst,
    sap3_ext_mem_if.slave mem
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [7:0]        mem_out_q, mem_out_d;
    logic              clr_pend_q, clr_pend_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_dat;
    logic              cpu_en;
    logic              ld_ready, ld_busy, ld_done;
    logic              unused_bus;

    logic [7:0] ram [DEPTH];

    // Address bits above ADDR_W are deliberately dropped so MAR wraps modulo DEPTH.
    assign unused_bus = ^mem.bus[15:ADDR_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mar_d      = mar_q;
        clr_pend_d = clr_pend_q;
        wr_en      = 1'b0;
        wr_addr    = mar_q;
        wr_dat     = mem.bus[7:0];
        cpu_en     = 1'b0;
        ld_ready   = 1'b0;
        ld_busy    = 1'b0;
        ld_done    = 1'b0;
        mem_out_d  = 8'h00;

        case (state_q)
            ST_CLEAR: begin
                ld_busy = 1'b1;
                wr_en   = 1'b1;
                wr_addr = cnt_q[ADDR_W-1:0];
                wr_dat  = 8'h00;
                cnt_d   = cnt_q + ONE_L;
                if (cnt_q == LAST_L) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_pend_q) begin
                    clr_pend_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_CLEAR;
                end else begin
                    cpu_en = 1'b1;
                    if (mem.ld_start) begin
                        len_d   = (mem.ld_len > DEPTH_L) ? DEPTH_L : mem.ld_len;
                        cnt_d   = '0;
                        state_d = (mem.ld_len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
                if (mem.ld_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = cnt_q[ADDR_W-1:0];
                    wr_dat  = mem.ld_data;
                    cnt_d   = cnt_q + ONE_L;
                    if (cnt_q + ONE_L == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ld_done = 1'b1;
                cpu_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The CPU write always targets the pre-update MAR.
        if (cpu_en) begin
            if (mem.mem_ram_we) begin
                wr_en   = 1'b1;
                wr_addr = mar_q;
                wr_dat  = mem.bus[7:0];
            end
            if (mem.mem_mar_we) begin
                mar_d = mem.bus[ADDR_W-1:0];
            end
        end

        if (state_q == ST_LOAD) begin
            mem_out_d = 8'h00;
        end else if (wr_en && (wr_addr == mar_d)) begin
            mem_out_d = wr_dat;
        end else begin
            mem_out_d = ram[mar_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mar_q      <= '0;
            mem_out_q  <= 8'h00;
            clr_pend_q <= INIT_ZERO;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mar_q      <= mar_d;
            mem_out_q  <= mem_out_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !rst) begin
            ram[wr_addr] <= wr_dat;
        end
    end

    assign mem.mem_out  = mem_out_q;
    assign mem.ld_ready = ld_ready;
    assign mem.ld_busy  = ld_busy;
    assign mem.ld_done  = ld_done;
endmodule

// File: tb/tb_sap3_ext_mem.sv
// Randomized bench for sap3_ext_mem against an array-based memory model.
module tb_sap3_ext_mem;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    sap3_ext_mem_if #(.ADDR_W(ADDR_W)) mif ();

    sap3_ext_mem #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b0)) dut (
        .CLK (CLK),
        .rst (rst),
        .mem (mif.slave)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_ram [DEPTH];
    logic [7:0] model_mar;
    logic [7:0] prog [4];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_op(input bit mw, input bit rw, input logic [15:0] b);
        mif.mem_mar_we = mw;
        mif.mem_ram_we = rw;
        mif.bus        = b;
        tick();
        mif.mem_mar_we = 1'b0;
        mif.mem_ram_we = 1'b0;
        if (rw) model_ram[model_mar] = b[7:0];
        if (mw) model_mar = b[7:0];
    endtask

    // Drives one load; mode 1 uses the fixed program and valid pattern 1,0,1,1,0,1.
    task automatic drive_load(input int len, input int exp_acc, input int mode,
                              output int acc, output int done_ok, output int zero_bad);
        bit         vbit;
        bit         acc_now;
        logic [7:0] dbyte;
        int         pat [6];
        pat      = '{1, 0, 1, 1, 0, 1};
        acc      = 0;
        done_ok  = 0;
        zero_bad = 0;
        mif.ld_start = 1'b1;
        mif.ld_len   = 9'(len);
        tick();
        mif.ld_start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vbit  = (mode == 1) ? (pat[cyc % 6] != 0) : ($urandom_range(0, 3) != 0);
            dbyte = (mode == 1) ? prog[acc % 4] : 8'($urandom);
            mif.ld_valid   = vbit;
            mif.ld_data    = dbyte;
            mif.ld_start   = $urandom_range(0, 1) == 1;
            mif.mem_ram_we = $urandom_range(0, 1) == 1;
            mif.mem_mar_we = $urandom_range(0, 1) == 1;
            mif.bus        = 16'($urandom);
            acc_now = mif.ld_ready && vbit;
            tick();
            if (acc_now) begin
                model_ram[acc] = dbyte;
                acc++;
            end
            if (mif.ld_done) begin
                done_ok = (acc_now && acc == exp_acc) ? 1 : 0;
                break;
            end
            if (mif.mem_out !== 8'h00) zero_bad++;
        end
        mif.ld_valid   = 1'b0;
        mif.ld_start   = 1'b0;
        mif.mem_ram_we = 1'b0;
        mif.mem_mar_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mif.bus = 16'hFFFF;
        mif.mem_mar_we = 1'b1;
        tick();
        tick();
        tests++; if (mif.mem_out !== 8'h00) begin fails++; $display("FAIL reset_mem_out: got %h want 00", mif.mem_out); end
        tests++; if (mif.ld_ready !== 1'b0) begin fails++; $display("FAIL reset_ld_ready: got %b want 0", mif.ld_ready); end
        tests++; if (mif.ld_busy !== 1'b0) begin fails++; $display("FAIL reset_ld_busy: got %b want 0", mif.ld_busy); end
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL reset_ld_done: got %b want 0", mif.ld_done); end
        mif.mem_mar_we = 1'b0;
        rst = 1'b0;
        model_mar = 8'h00;
    endtask

    task automatic test_load_overflow();
        int acc, done_ok, zero_bad;
        logic [7:0] a;
        drive_load(300, DEPTH, 0, acc, done_ok, zero_bad);
        tests++; if (acc != DEPTH) begin fails++; $display("FAIL ovf_accepts: got %0d want %0d", acc, DEPTH); end
        tests++; if (done_ok != 1) begin fails++; $display("FAIL ovf_done_timing: got %0d want 1", done_ok); end
        tests++; if (zero_bad != 0) begin fails++; $display("FAIL ovf_mem_out_zero: got %0d nonzero cycles want 0", zero_bad); end
        tick();
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL ovf_done_width: got %b want 0", mif.ld_done); end
        tests++; if (mif.ld_busy !== 1'b0) begin fails++; $display("FAIL ovf_busy_after: got %b want 0", mif.ld_busy); end
        tests++; if (mif.mem_out !== model_ram[model_mar]) begin fails++; $display("FAIL ovf_mar_kept: got %h want %h", mif.mem_out, model_ram[model_mar]); end
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom);
            cpu_op(1'b1, 1'b0, {8'($urandom), a});
            tests++; if (mif.mem_out !== model_ram[a]) begin fails++; $display("FAIL ovf_readback[%0h]: got %h want %h", a, mif.mem_out, model_ram[a]); end
        end
    endtask

    task automatic test_round_trip();
        cpu_op(1'b1, 1'b0, 16'h0010);
        cpu_op(1'b0, 1'b1, 16'h00A5);
        tests++; if (mif.mem_out !== 8'hA5) begin fails++; $display("FAIL rt_write_first: got %h want a5", mif.mem_out); end
        cpu_op(1'b1, 1'b0, 16'h0011);
        tests++; if (mif.mem_out !== model_ram[8'h11]) begin fails++; $display("FAIL rt_mar_read: got %h want %h", mif.mem_out, model_ram[8'h11]); end
    endtask

    task automatic test_simultaneous();
        cpu_op(1'b1, 1'b0, 16'h0020);
        cpu_op(1'b1, 1'b1, 16'h0030);
        tests++; if (mif.mem_out !== model_ram[8'h30]) begin fails++; $display("FAIL sim_new_mar: got %h want %h", mif.mem_out, model_ram[8'h30]); end
        cpu_op(1'b1, 1'b0, 16'h0020);
        tests++; if (mif.mem_out !== 8'h30) begin fails++; $display("FAIL sim_old_mar_write: got %h want 30", mif.mem_out); end
    endtask

    task automatic test_wrap();
        cpu_op(1'b1, 1'b0, 16'h1205);
        cpu_op(1'b0, 1'b1, 16'h0077);
        cpu_op(1'b1, 1'b0, 16'h0000);
        cpu_op(1'b1, 1'b0, 16'h0005);
        tests++; if (mif.mem_out !== 8'h77) begin fails++; $display("FAIL wrap_addr5: got %h want 77", mif.mem_out); end
    endtask

    task automatic test_load_stalls();
        int acc, done_ok, zero_bad;
        logic [7:0] want [4];
        want = '{8'h3E, 8'h01, 8'hD3, 8'h76};
        drive_load(4, 4, 1, acc, done_ok, zero_bad);
        tests++; if (acc != 4) begin fails++; $display("FAIL stall_accepts: got %0d want 4", acc); end
        tests++; if (done_ok != 1) begin fails++; $display("FAIL stall_done_timing: got %0d want 1", done_ok); end
        tests++; if (zero_bad != 0) begin fails++; $display("FAIL stall_mem_out_zero: got %0d want 0", zero_bad); end
        tick();
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL stall_done_width: got %b want 0", mif.ld_done); end
        tests++; if (mif.mem_out !== model_ram[model_mar]) begin fails++; $display("FAIL stall_mar_kept: got %h want %h", mif.mem_out, model_ram[model_mar]); end
        for (int i = 0; i < 4; i++) begin
            cpu_op(1'b1, 1'b0, 16'(i));
            tests++; if (mif.mem_out !== want[i]) begin fails++; $display("FAIL stall_prog[%0d]: got %h want %h", i, mif.mem_out, want[i]); end
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] keep;
        cpu_op(1'b1, 1'b0, 16'h0000);
        keep = model_ram[0];
        mif.ld_start = 1'b1;
        mif.ld_len   = 9'd0;
        mif.ld_valid = 1'b1;
        mif.ld_data  = ~keep;
        tick();
        mif.ld_start = 1'b0;
        tests++; if (mif.ld_done !== 1'b1) begin fails++; $display("FAIL zero_done: got %b want 1", mif.ld_done); end
        tests++; if (mif.ld_busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b want 0", mif.ld_busy); end
        tick();
        mif.ld_valid = 1'b0;
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL zero_done_width: got %b want 0", mif.ld_done); end
        cpu_op(1'b1, 1'b0, 16'h0000);
        tests++; if (mif.mem_out !== keep) begin fails++; $display("FAIL zero_no_write: got %h want %h", mif.mem_out, keep); end
    endtask

    task automatic test_reset_mid_load();
        int acc, done_ok, zero_bad;
        logic [7:0] first [3];
        mif.ld_start = 1'b1;
        mif.ld_len   = 9'd8;
        tick();
        mif.ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            first[i]     = 8'($urandom);
            mif.ld_valid = 1'b1;
            mif.ld_data  = first[i];
            tick();
            model_ram[i] = first[i];
        end
        mif.ld_valid = 1'b0;
        tests++; if (mif.ld_busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", mif.ld_busy); end
        rst = 1'b1;
        tick();
        tests++; if (mif.ld_busy !== 1'b0) begin fails++; $display("FAIL mid_busy_reset: got %b want 0", mif.ld_busy); end
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL mid_no_done: got %b want 0", mif.ld_done); end
        rst = 1'b0;
        model_mar = 8'h00;
        tick();
        tests++; if (mif.ld_done !== 1'b0) begin fails++; $display("FAIL mid_no_done_late: got %b want 0", mif.ld_done); end
        for (int i = 0; i < 3; i++) begin
            cpu_op(1'b1, 1'b0, 16'(i));
            tests++; if (mif.mem_out !== first[i]) begin fails++; $display("FAIL mid_kept[%0d]: got %h want %h", i, mif.mem_out, first[i]); end
        end
        drive_load(2, 2, 0, acc, done_ok, zero_bad);
        tests++; if (acc != 2 || done_ok != 1) begin fails++; $display("FAIL mid_reload: got acc %0d done_ok %0d want 2 1", acc, done_ok); end
        tick();
        for (int i = 0; i < 3; i++) begin
            cpu_op(1'b1, 1'b0, 16'(i));
            tests++; if (mif.mem_out !== model_ram[i]) begin fails++; $display("FAIL mid_reload_data[%0d]: got %h want %h", i, mif.mem_out, model_ram[i]); end
        end
    endtask

    task automatic test_random_cpu();
        for (int i = 0; i < 300; i++) begin
            cpu_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom));
            tests++; if (mif.mem_out !== model_ram[model_mar]) begin fails++; $display("FAIL rand_cpu[%0d]: got %h want %h", i, mif.mem_out, model_ram[model_mar]); end
        end
    endtask

    initial begin
        mif.bus        = 16'h0000;
        mif.mem_mar_we = 1'b0;
        mif.mem_ram_we = 1'b0;
        mif.ld_start   = 1'b0;
        mif.ld_len     = '0;
        mif.ld_valid   = 1'b0;
        mif.ld_data    = 8'h00;
        model_mar      = 8'h00;
        prog           = '{8'h3E, 8'h01, 8'hD3, 8'h76};
        test_reset();
        test_load_overflow();
        test_round_trip();
        test_simultaneous();
        test_wrap();
        test_load_stalls();
        test_zero_len();
        test_reset_mid_load();
        test_random_cpu();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
